// File: rtl/alu_pkg.sv
// Shared ALU definitions: iterative-shifter FSM states, default widths and op encodings.
package alu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  // SRA op code, shared with the execute-stage decoder
  localparam logic [3:0] ALU_OP_SRA = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/sra_step.sv
// One-bit arithmetic right shift; mirror of the one-bit left-shift ALU op.
module sra_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = {x[WIDTH-1], x[WIDTH-1:1]};
endmodule

// File: rtl/sra_iter.sv
// Iterative arithmetic right shifter: one sign-preserving shift per clock, done pulse on completion.
module sra_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_step;
  logic [SHW-1:0]   cnt;
  logic             accept;
  logic             unused_b;

  assign unused_b = ^b[WIDTH-1:SHW];

  sra_step #(.WIDTH(WIDTH)) u_step (.x(acc), .y(acc_step));

  // DONE accepts a new start just like IDLE, allowing back-to-back ops
  assign accept = start && (state != SHIFT);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (b[SHW-1:0] == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == SHW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (b[SHW-1:0] == '0) ? DONE : SHIFT;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= a;
        cnt <= b[SHW-1:0];
      end else if (state == SHIFT) begin
        acc <= acc_step;
        cnt <= cnt - SHW'(1);
      end
    end
  end

  assign out = acc;
endmodule
